// File: rtl/pwm_duty_meter_if.sv
// Signal bundle between a PWM duty meter and its environment: the PWM input
// plus the binary duty result, event pulses and the four 7-segment digits.
interface pwm_duty_meter_if;
    logic       pwm_in;
    logic [7:0] d;
    logic       valid;
    logic       ovr;
    logic [0:6] d0;
    logic [0:6] d1;
    logic [0:6] d2;
    logic [0:6] d3;

    modport master (
        output pwm_in,
        input  d, valid, ovr, d0, d1, d2, d3
    );

    modport slave (
        input  pwm_in,
        output d, valid, ovr, d0, d1, d2, d3
    );
endinterface

// File: rtl/pwm_duty_meter.sv
// Measures the duty cycle of an asynchronous PWM input as an integer percentage
// (0..100) and drives it as binary plus a four-digit active-low 7-segment display.
module pwm_duty_meter #(
    parameter int CNT_W    = 16,
    parameter int SYNC_STG = 2
) (
    input  logic             clkin,
    input  logic             reset,
    pwm_duty_meter_if.slave  bus
);

    localparam int                DW       = CNT_W + 7;
    localparam int                IT_W     = $clog2(DW + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [IT_W-1:0]   IT_LAST  = IT_W'(DW - 1);
    localparam logic [IT_W-1:0]   IT_ONE   = IT_W'(1);
    localparam logic [DW-1:0]     HUNDRED  = DW'(100);
    localparam logic [0:6]        SEG_BLANK = 7'b1111111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    function automatic logic [0:6] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    logic [SYNC_STG-1:0] sync_r;
    logic                pwm_q_r;
    logic                pwm_sync_s;
    logic                rise_s;

    state_t              state_r, state_nxt_s;
    logic [CNT_W-1:0]    per_cnt_r, per_nxt_s;
    logic [CNT_W-1:0]    hi_cnt_r, hi_nxt_s;
    logic                start_s, ovr_s, tmo_s;
    logic [7:0]          tmo_d_s;

    logic                busy_r;
    logic [IT_W-1:0]     it_r;
    logic [DW-1:0]       quo_r, quo_nxt_s;
    logic [CNT_W:0]      rem_r, rem_nxt_s, rem_sh_s;
    logic [CNT_W-1:0]    dvs_r;
    logic [DW-1:0]       dvd_s;
    logic [7:0]          res_s;
    logic                div_done_s;

    logic [7:0]          d_r;
    logic                valid_r, ovr_r;
    logic [0:6]          d0_r, d1_r, d2_r, d3_r;
    logic                hund_s;
    logic [7:0]          rem100_s;
    logic [3:0]          tens_s, ones_s;

    assign pwm_sync_s = sync_r[SYNC_STG-1];
    assign rise_s     = pwm_sync_s & ~pwm_q_r;
    assign tmo_d_s    = pwm_sync_s ? 8'd100 : 8'd0;
    assign dvd_s      = DW'(hi_cnt_r) * HUNDRED;
    assign div_done_s = busy_r && (it_r == IT_LAST);

    // Synchronizer chain and edge-detect delay flop
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            sync_r  <= {SYNC_STG{1'b0}};
            pwm_q_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STG-2:0], bus.pwm_in};
            pwm_q_r <= pwm_sync_s;
        end
    end

    // Measurement FSM: counter update, divider start, overrun and timeout decisions
    always_comb begin
        state_nxt_s = state_r;
        per_nxt_s   = per_cnt_r;
        hi_nxt_s    = hi_cnt_r;
        start_s     = 1'b0;
        ovr_s       = 1'b0;
        tmo_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_nxt_s = MEAS;
                    per_nxt_s   = CNT_ONE;
                    hi_nxt_s    = CNT_ONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MEAS: begin
                // A rise outranks a simultaneous timeout; cycle R opens the next period
                if (rise_s) begin
                    per_nxt_s = CNT_ONE;
                    hi_nxt_s  = CNT_ONE;
                    if (busy_r) begin
                        ovr_s = 1'b1;
                    end else begin
                        start_s = 1'b1;
                    end
                end else if (per_cnt_r == CNT_MAX) begin
                    tmo_s       = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    per_nxt_s = per_cnt_r + CNT_ONE;
                    if (pwm_sync_s && (hi_cnt_r != CNT_MAX)) begin
                        hi_nxt_s = hi_cnt_r + CNT_ONE;
                    end else begin
                        hi_nxt_s = hi_cnt_r;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state and period/high-time counters
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            per_cnt_r <= {CNT_W{1'b0}};
            hi_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            per_cnt_r <= per_nxt_s;
            hi_cnt_r  <= hi_nxt_s;
        end
    end

    // One restoring shift-subtract step of (hi*100)/per, plus the clamped result
    always_comb begin
        rem_sh_s = {rem_r[CNT_W-1:0], quo_r[DW-1]};
        if (rem_sh_s >= {1'b0, dvs_r}) begin
            rem_nxt_s = rem_sh_s - {1'b0, dvs_r};
            quo_nxt_s = {quo_r[DW-2:0], 1'b1};
        end else begin
            rem_nxt_s = rem_sh_s;
            quo_nxt_s = {quo_r[DW-2:0], 1'b0};
        end
        if (quo_nxt_s > HUNDRED) begin
            res_s = 8'd100;
        end else begin
            res_s = quo_nxt_s[7:0];
        end
    end

    // Divider engine; a timeout abandons any division in flight
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            busy_r <= 1'b0;
            it_r   <= {IT_W{1'b0}};
            quo_r  <= {DW{1'b0}};
            rem_r  <= {(CNT_W+1){1'b0}};
            dvs_r  <= {CNT_W{1'b0}};
        end else if (tmo_s) begin
            busy_r <= 1'b0;
        end else if (start_s) begin
            busy_r <= 1'b1;
            it_r   <= {IT_W{1'b0}};
            quo_r  <= dvd_s;
            rem_r  <= {(CNT_W+1){1'b0}};
            dvs_r  <= per_cnt_r;
        end else if (busy_r) begin
            quo_r  <= quo_nxt_s;
            rem_r  <= rem_nxt_s;
            it_r   <= it_r + IT_ONE;
            busy_r <= !div_done_s;
        end else begin
            busy_r <= 1'b0;
        end
    end

    // Result register and event pulses
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            d_r     <= 8'd0;
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            ovr_r <= ovr_s;
            if (tmo_s) begin
                d_r     <= tmo_d_s;
                valid_r <= 1'b1;
            end else if (div_done_s) begin
                d_r     <= res_s;
                valid_r <= 1'b1;
            end else begin
                valid_r <= 1'b0;
            end
        end
    end

    // Binary to BCD split of the 0..100 result
    always_comb begin
        if (d_r >= 8'd100) begin
            hund_s   = 1'b1;
            rem100_s = d_r - 8'd100;
        end else begin
            hund_s   = 1'b0;
            rem100_s = d_r;
        end
        tens_s = 4'(rem100_s / 8'd10);
        ones_s = 4'(rem100_s % 8'd10);
    end

    // Display registers with leading-zero blanking
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            d0_r <= 7'b0000001;
            d1_r <= SEG_BLANK;
            d2_r <= SEG_BLANK;
            d3_r <= SEG_BLANK;
        end else begin
            d0_r <= seg7(ones_s);
            d1_r <= (d_r < 8'd10) ? SEG_BLANK : seg7(tens_s);
            d2_r <= hund_s ? seg7(4'd1) : SEG_BLANK;
            d3_r <= SEG_BLANK;
        end
    end

    assign bus.d     = d_r;
    assign bus.valid = valid_r;
    assign bus.ovr   = ovr_r;
    assign bus.d0    = d0_r;
    assign bus.d1    = d1_r;
    assign bus.d2    = d2_r;
    assign bus.d3    = d3_r;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: a CNT_W=16 instance for duty, latency and
// overrun cases, and a CNT_W=8 instance so both timeout paths fit a short run.
module tb_pwm_duty_meter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pwm_duty_meter_if bus ();
    pwm_duty_meter_if tbus ();

    pwm_duty_meter #(.CNT_W(16), .SYNC_STG(2)) dut (
        .clkin (clk),
        .reset (reset),
        .bus   (bus)
    );

    pwm_duty_meter #(.CNT_W(8), .SYNC_STG(2)) dut_t (
        .clkin (clk),
        .reset (reset),
        .bus   (tbus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vcnt  = 0;
    int ocnt  = 0;
    int tvcnt = 0;
    int last_vcyc = 0;
    int rise_cyc  = 0;
    int watch_d   = -1;
    int hit_cyc   = -1;

    // Event monitor, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (bus.valid === 1'b1) begin
            vcnt = vcnt + 1;
            last_vcyc = cyc;
            if (hit_cyc < 0 && int'(bus.d) == watch_d) hit_cyc = cyc;
        end
        if (bus.ovr === 1'b1) ocnt = ocnt + 1;
        if (tbus.valid === 1'b1) tvcnt = tvcnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_pwm(input int per, input int hi, input int n);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < per; c++) begin
                @(negedge clk);
                if (c == 0) rise_cyc = cyc;
                bus.pwm_in = (c < hi);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.pwm_in = 1'b0;
        tbus.pwm_in = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(2);
        vcnt = 0; ocnt = 0; tvcnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.pwm_in = 1'b0;
        tbus.pwm_in = 1'b0;
        tick(3);
        total++; if (bus.d !== 8'd0) begin bad++; $display("FAIL rst_d got=%0d want=0", bus.d); end
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.valid); end
        total++; if (bus.ovr !== 1'b0) begin bad++; $display("FAIL rst_ovr got=%b want=0", bus.ovr); end
        total++; if (bus.d0 !== 7'b0000001) begin bad++; $display("FAIL rst_d0 got=%b want=0000001", bus.d0); end
        total++; if (bus.d1 !== 7'b1111111) begin bad++; $display("FAIL rst_d1 got=%b want=1111111", bus.d1); end
        total++; if (bus.d2 !== 7'b1111111) begin bad++; $display("FAIL rst_d2 got=%b want=1111111", bus.d2); end
        total++; if (bus.d3 !== 7'b1111111) begin bad++; $display("FAIL rst_d3 got=%b want=1111111", bus.d3); end
        total++; if (tbus.d !== 8'd0) begin bad++; $display("FAIL rst_t_d got=%0d want=0", tbus.d); end
        reset = 1'b1;
        tick(2);
    endtask

    task automatic test_duty25();
        do_reset();
        run_pwm(100, 25, 3);
        total++; if (vcnt !== 2) begin bad++; $display("FAIL d25_vcnt got=%0d want=2", vcnt); end
        total++; if (bus.d !== 8'd25) begin bad++; $display("FAIL d25_d got=%0d want=25", bus.d); end
        total++; if (last_vcyc - rise_cyc !== 26) begin bad++; $display("FAIL d25_latency got=%0d want=26", last_vcyc - rise_cyc); end
        total++; if (bus.d0 !== 7'b0100100) begin bad++; $display("FAIL d25_d0 got=%b want=0100100", bus.d0); end
        total++; if (bus.d1 !== 7'b0010010) begin bad++; $display("FAIL d25_d1 got=%b want=0010010", bus.d1); end
        total++; if (bus.d2 !== 7'b1111111) begin bad++; $display("FAIL d25_d2 got=%b want=1111111", bus.d2); end
        total++; if (ocnt !== 0) begin bad++; $display("FAIL d25_ovr got=%0d want=0", ocnt); end
    endtask

    task automatic test_duty7();
        do_reset();
        run_pwm(100, 7, 2);
        tick(30);
        total++; if (vcnt !== 1) begin bad++; $display("FAIL d7_vcnt got=%0d want=1", vcnt); end
        total++; if (bus.d !== 8'd7) begin bad++; $display("FAIL d7_d got=%0d want=7", bus.d); end
        total++; if (bus.d0 !== 7'b0001111) begin bad++; $display("FAIL d7_d0 got=%b want=0001111", bus.d0); end
        total++; if (bus.d1 !== 7'b1111111) begin bad++; $display("FAIL d7_d1 got=%b want=1111111", bus.d1); end
    endtask

    task automatic test_overrun();
        do_reset();
        run_pwm(3, 1, 9);
        tick(40);
        total++; if (ocnt !== 7) begin bad++; $display("FAIL ovr_cnt got=%0d want=7", ocnt); end
        total++; if (vcnt !== 1) begin bad++; $display("FAIL ovr_vcnt got=%0d want=1", vcnt); end
        total++; if (bus.d !== 8'd33) begin bad++; $display("FAIL ovr_d got=%0d want=33", bus.d); end
        total++; if (bus.d0 !== 7'b0000110) begin bad++; $display("FAIL ovr_d0 got=%b want=0000110", bus.d0); end
        total++; if (bus.d1 !== 7'b0000110) begin bad++; $display("FAIL ovr_d1 got=%b want=0000110", bus.d1); end
    endtask

    task automatic test_min_period();
        do_reset();
        run_pwm(24, 6, 4);
        tick(30);
        total++; if (vcnt !== 3) begin bad++; $display("FAIL p24_vcnt got=%0d want=3", vcnt); end
        total++; if (ocnt !== 0) begin bad++; $display("FAIL p24_ovr got=%0d want=0", ocnt); end
        total++; if (bus.d !== 8'd25) begin bad++; $display("FAIL p24_d got=%0d want=25", bus.d); end
        do_reset();
        run_pwm(23, 6, 4);
        tick(30);
        total++; if (vcnt !== 2) begin bad++; $display("FAIL p23_vcnt got=%0d want=2", vcnt); end
        total++; if (ocnt !== 1) begin bad++; $display("FAIL p23_ovr got=%0d want=1", ocnt); end
        total++; if (bus.d !== 8'd26) begin bad++; $display("FAIL p23_d got=%0d want=26", bus.d); end
        total++; if (bus.d0 !== 7'b0100000) begin bad++; $display("FAIL p23_d0 got=%b want=0100000", bus.d0); end
    endtask

    task automatic test_back_to_back();
        int chg;
        do_reset();
        run_pwm(100, 50, 3);
        total++; if (bus.d !== 8'd50) begin bad++; $display("FAIL step50_d got=%0d want=50", bus.d); end
        total++; if (vcnt !== 2) begin bad++; $display("FAIL step50_vcnt got=%0d want=2", vcnt); end
        watch_d = 60;
        hit_cyc = -1;
        chg = cyc + 1;
        run_pwm(100, 60, 3);
        total++; if (bus.d !== 8'd60) begin bad++; $display("FAIL step60_d got=%0d want=60", bus.d); end
        total++; if (vcnt !== 5) begin bad++; $display("FAIL step60_vcnt got=%0d want=5", vcnt); end
        total++; if (hit_cyc - chg !== 126) begin bad++; $display("FAIL step60_track got=%0d want=126", hit_cyc - chg); end
    endtask

    task automatic test_reset_mid_divide();
        do_reset();
        run_pwm(100, 25, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.pwm_in = 1'b1;
        end
        reset = 1'b0;
        bus.pwm_in = 1'b0;
        tick(3);
        total++; if (bus.d !== 8'd0) begin bad++; $display("FAIL midrst_d got=%0d want=0", bus.d); end
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", bus.valid); end
        reset = 1'b1;
        tick(5);
        run_pwm(100, 25, 1);
        total++; if (vcnt !== 0) begin bad++; $display("FAIL midrst_one_rise got=%0d want=0", vcnt); end
        run_pwm(100, 25, 1);
        total++; if (vcnt !== 1) begin bad++; $display("FAIL midrst_two_rise got=%0d want=1", vcnt); end
        total++; if (bus.d !== 8'd25) begin bad++; $display("FAIL midrst_d25 got=%0d want=25", bus.d); end
        total++; if (last_vcyc - rise_cyc !== 26) begin bad++; $display("FAIL midrst_latency got=%0d want=26", last_vcyc - rise_cyc); end
    endtask

    task automatic test_timeout();
        do_reset();
        @(negedge clk);
        tbus.pwm_in = 1'b1;
        for (int i = 0; i < 400 && tvcnt == 0; i++) tick(1);
        total++; if (tvcnt !== 1) begin bad++; $display("FAIL tmo_hi_wait got=%0d want=1", tvcnt); end
        total++; if (tbus.d !== 8'd100) begin bad++; $display("FAIL tmo_hi_d got=%0d want=100", tbus.d); end
        tick(2);
        total++; if (tbus.d2 !== 7'b1001111) begin bad++; $display("FAIL tmo_hi_d2 got=%b want=1001111", tbus.d2); end
        total++; if (tbus.d1 !== 7'b0000001) begin bad++; $display("FAIL tmo_hi_d1 got=%b want=0000001", tbus.d1); end
        total++; if (tbus.d0 !== 7'b0000001) begin bad++; $display("FAIL tmo_hi_d0 got=%b want=0000001", tbus.d0); end
        tick(300);
        total++; if (tvcnt !== 1) begin bad++; $display("FAIL tmo_idle got=%0d want=1", tvcnt); end
        tbus.pwm_in = 1'b0;
        tick(5);
        tbus.pwm_in = 1'b1;
        tick(3);
        tbus.pwm_in = 1'b0;
        for (int i = 0; i < 400 && tvcnt < 2; i++) tick(1);
        total++; if (tvcnt !== 2) begin bad++; $display("FAIL tmo_lo_wait got=%0d want=2", tvcnt); end
        total++; if (tbus.d !== 8'd0) begin bad++; $display("FAIL tmo_lo_d got=%0d want=0", tbus.d); end
        tick(2);
        total++; if (tbus.d0 !== 7'b0000001) begin bad++; $display("FAIL tmo_lo_d0 got=%b want=0000001", tbus.d0); end
        total++; if (tbus.d1 !== 7'b1111111) begin bad++; $display("FAIL tmo_lo_d1 got=%b want=1111111", tbus.d1); end
        total++; if (tbus.d2 !== 7'b1111111) begin bad++; $display("FAIL tmo_lo_d2 got=%b want=1111111", tbus.d2); end
    endtask

    initial begin
        test_reset();
        test_duty25();
        test_duty7();
        test_overrun();
        test_min_period();
        test_back_to_back();
        test_reset_mid_divide();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
Measures the duty cycle of an incoming PWM waveform and reports it as an integer percentage 0..100. This is the receive-side counterpart of the clkduty PWM generator. It is used in loopback self-test and to read externally supplied PWM. It drives the same four 7-segment digit ports and 8-bit duty bus as the generator, so both can share a display.

Parameters:
CNT_W, 16, width of the high-time and period counters in clkin cycles; this also sets the timeout at 2^CNT_W-1 cycles.
SYNC_STG, 2, number of synchronizer flops on pwm_in (minimum 2).

Ports:
clkin  input  1  system clock; all logic on posedge.
reset  input  1  asynchronous, active-low reset.
pwm_in  input  1  asynchronous PWM input.
d  output  8  last measured duty in percent (0..100), binary.
valid  output  1  one-cycle pulse when d updates.
ovr  output  1  one-cycle pulse when a measurement is dropped because the divider is busy.
d0  output  [0:6]  ones digit; segments a..g, active-low.
d1  output  [0:6]  tens digit; blank when d<10.
d2  output  [0:6]  hundreds digit; shows '1' only when d==100, otherwise blank.
d3  output  [0:6]  always blank (7'b1111111).

Behaviour:
- Reset (reset=0, async): d=0, valid=0, ovr=0, d0='0' (0000001), d1=d2=d3=1111111. State=IDLE, all counters 0, synchronizer flops 0.
- pwm_in passes through SYNC_STG flops to give pwm_s. Rise = pwm_s & ~pwm_s_q. Cycle R is the cycle in which rise is high.
- FSM states: IDLE, MEAS. The divider runs alongside the FSM as a separate engine with its own busy flag.
- IDLE: wait for rise. On rise, clear per_cnt and hi_cnt, then go to MEAS. No result is produced from this first edge.
- MEAS counting: per_cnt increments every cycle. hi_cnt increments every cycle where pwm_s=1. Both counters include cycle R itself; per_cnt=1 and hi_cnt=1 after the first cycle.
- MEAS on rise, divider idle: snapshot per_cnt and hi_cnt, start the divider, and restart both counters at 1 in the same cycle.
- MEAS on rise, divider busy: discard the snapshot, pulse ovr for 1 cycle, and restart the counters. The divider continues undisturbed.
- MEAS timeout: if per_cnt reaches 2^CNT_W-1 with no rise, set d=100 if pwm_s=1, else d=0. Pulse valid, go to IDLE. Counters saturate and do not wrap.
- Divider: restoring shift-subtract computing quotient = (hi*100)/per, truncated. The dividend is CNT_W+7 bits and the quotient is held in CNT_W+7 bits. It takes exactly CNT_W+7 iterations, one per cycle, over cycles R+1..R+CNT_W+7.
- Result: at R+CNT_W+8, d is loaded with the quotient clamped to 100 and valid=1 for that single cycle. The busy flag clears in the same cycle.
- Worked latency for CNT_W=16: a rise at cycle R gives valid at R+24.
- Minimum measurable period is CNT_W+8 cycles. Shorter periods produce ovr pulses and keep the last good d.
- Divide-by-zero is impossible because per>=1. hi==per gives 100; constant-low input never reaches the divider (timeout path handles it).
- Display: a registered binary-to-BCD conversion of d updates d0..d2 one cycle after d changes.
- Segment patterns ([0:6]=a..g, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, blank=1111111.
- Simultaneous timeout and rise: rise wins and the measurement is taken normally.
- A timeout while the divider is busy drops the divider result. d takes the timeout value; only one valid pulse is issued.
- Reset mid-divide: the result is abandoned, outputs return to reset values, and the next result needs two fresh rises.

Test Plan:
- PWM period 100 cycles, high 25, three periods -> first valid about 24 cycles after the 2nd rise; d=25, d0=0100100, d1=0010010, d2=1111111; identical on the 3rd period.
- pwm_in constant 1 after one rise, held for 65535+ cycles -> valid once, d=100, d2=1001111, d1=0000001, d0=0000001; FSM returns to IDLE.
- pwm_in constant 0 after one rise -> timeout gives d=0, d1=d2=blank, d0=0000001.
- Period 100 cycles, high 7 -> d=7, d1 blank; period 3 cycles, high 1 -> ovr pulses every rise after the first accepted one, with no further valid pulses while overrun persists.
- Loopback with clkduty output, duty stepped 50->60 via inc1 pulses -> d tracks 50 then 60, with each new value within 2 periods plus 24 cycles of the change.
- Assert reset mid-divide (R+10) -> d=0, valid stays 0; after release, two rises are required before the next valid.
